// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REFILL = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Byte offset bits within a line (beat offset plus beat select).
  function automatic int unsigned off_bits(input int unsigned line_beats);
    return BEAT_SHIFT + $clog2(line_beats);
  endfunction

  // Set index bits.
  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag bits of a 64-bit address.
  function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned line_beats);
    return 64 - off_bits(line_beats) - idx_bits(lines);
  endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Valid/tag/data storage: combinational tag lookup, registered 32-bit read,
// one write port and a bulk valid clear.
module icache_dm_array
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_BEATS = 4,
  localparam int unsigned IB = idx_bits(LINES),
  localparam int unsigned BW = $clog2(LINE_BEATS),
  localparam int unsigned TW = tag_bits(LINES, LINE_BEATS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IB-1:0] lookup_index,
  output logic          lookup_valid_c,
  output logic [TW-1:0] lookup_tag_c,
  input  logic          rd_en,
  input  logic [IB-1:0] rd_index,
  input  logic [BW-1:0] rd_beat,
  input  logic          rd_word,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IB-1:0] wr_index,
  input  logic [BW-1:0] wr_beat,
  input  logic [63:0]   wr_data,
  input  logic          tag_en,
  input  logic [TW-1:0] tag_data,
  input  logic          tag_valid,
  input  logic          clear_all
);

  localparam int unsigned DEPTH = LINES * LINE_BEATS;

  logic [63:0]      data_mem [DEPTH];
  logic [TW-1:0]    tag_mem  [LINES];
  logic [LINES-1:0] valid_q;
  logic [63:0]      rd_src_c;

  assign lookup_valid_c = valid_q[lookup_index];
  assign lookup_tag_c   = tag_mem[lookup_index];

  // Read source, forwarding a beat being written in the same cycle.
  always_comb begin
    rd_src_c = data_mem[{rd_index, rd_beat}];
    if (wr_en && (wr_index == rd_index) && (wr_beat == rd_beat)) begin
      rd_src_c = wr_data;
    end
  end

  // Data and tag storage writes.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[{wr_index, wr_beat}] <= wr_data;
    end
    if (tag_en) begin
      tag_mem[wr_index] <= tag_data;
    end
  end

  // Valid bits with bulk clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (tag_en) begin
      valid_q[wr_index] <= tag_valid;
    end
  end

  // Registered word read; holds while rd_en is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_word ? rd_src_c[63:32] : rd_src_c[31:0];
    end
  end

endmodule

// File: rtl/icache_dm_fetch.sv
// Direct-mapped read-only instruction cache: hit path, line refill over a
// valid/ready memory port, flush for fence.i, hit/miss counters.
module icache_dm_fetch
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_BEATS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_cmd_valid,
  output logic        cpu_cmd_ready,
  input  logic [63:0] cpu_cmd_addr,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_data,
  input  logic        flush,
  output logic        mem_cmd_valid,
  input  logic        mem_cmd_ready,
  output logic [63:0] mem_cmd_addr,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned OB = off_bits(LINE_BEATS);
  localparam int unsigned IB = idx_bits(LINES);
  localparam int unsigned TW = tag_bits(LINES, LINE_BEATS);
  localparam int unsigned BW = $clog2(LINE_BEATS);

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] issue_cnt, issue_nxt, recv_cnt, recv_nxt;
  logic [IB-1:0] req_index, req_index_nxt;
  logic [TW-1:0] req_tag, req_tag_nxt;
  logic [BW-1:0] req_beat, req_beat_nxt;
  logic          req_word, req_word_nxt;
  logic          flush_pend, flush_pend_nxt;
  logic          cmd_ready_nxt, rsp_valid_nxt, mem_valid_nxt;
  logic [63:0]   mem_addr_nxt;
  logic [31:0]   hit_nxt, miss_nxt;

  logic          a_word;
  logic [BW-1:0] a_beat;
  logic [IB-1:0] a_index;
  logic [TW-1:0] a_tag;
  logic          unused_addr_lsbs;

  logic          lookup_valid_c;
  logic [TW-1:0] lookup_tag_c;
  logic          accept, hit_c;
  logic          rd_en, rd_word, wr_en, tag_en, tag_valid, clear_all;
  logic [IB-1:0] rd_index;
  logic [BW-1:0] rd_beat;

  assign a_word           = cpu_cmd_addr[BEAT_SHIFT-1];
  assign a_beat           = cpu_cmd_addr[OB-1:BEAT_SHIFT];
  assign a_index          = cpu_cmd_addr[OB+IB-1:OB];
  assign a_tag            = cpu_cmd_addr[63:OB+IB];
  assign unused_addr_lsbs = ^cpu_cmd_addr[1:0];

  assign accept = cpu_cmd_valid && cpu_cmd_ready;
  assign hit_c  = lookup_valid_c && (lookup_tag_c == a_tag);

  icache_dm_array #(
    .LINES      (LINES),
    .LINE_BEATS (LINE_BEATS)
  ) u_array (
    .clock          (clock),
    .reset          (reset),
    .lookup_index   (a_index),
    .lookup_valid_c (lookup_valid_c),
    .lookup_tag_c   (lookup_tag_c),
    .rd_en          (rd_en),
    .rd_index       (rd_index),
    .rd_beat        (rd_beat),
    .rd_word        (rd_word),
    .rd_data        (cpu_rsp_data),
    .wr_en          (wr_en),
    .wr_index       (req_index),
    .wr_beat        (recv_cnt),
    .wr_data        (mem_rsp_data),
    .tag_en         (tag_en),
    .tag_data       (req_tag),
    .tag_valid      (tag_valid),
    .clear_all      (clear_all)
  );

  // Next-state, array control and output-register next values.
  always_comb begin
    state_nxt      = state;
    issue_nxt      = issue_cnt;
    recv_nxt       = recv_cnt;
    req_index_nxt  = req_index;
    req_tag_nxt    = req_tag;
    req_beat_nxt   = req_beat;
    req_word_nxt   = req_word;
    flush_pend_nxt = flush_pend;
    cmd_ready_nxt  = cpu_cmd_ready;
    rsp_valid_nxt  = 1'b0;
    mem_valid_nxt  = mem_cmd_valid;
    mem_addr_nxt   = mem_cmd_addr;
    hit_nxt        = hit_count;
    miss_nxt       = miss_count;
    rd_en          = 1'b0;
    rd_index       = a_index;
    rd_beat        = a_beat;
    rd_word        = a_word;
    wr_en          = 1'b0;
    tag_en         = 1'b0;
    tag_valid      = 1'b0;
    clear_all      = 1'b0;

    case (state)
      ST_IDLE: begin
        // Lookup sees the pre-flush valid bits; the clear lands at the edge.
        clear_all = flush;
        if (accept) begin
          if (hit_c) begin
            rd_en         = 1'b1;
            rsp_valid_nxt = 1'b1;
            hit_nxt       = hit_count + 32'd1;
          end else begin
            miss_nxt      = miss_count + 32'd1;
            req_index_nxt = a_index;
            req_tag_nxt   = a_tag;
            req_beat_nxt  = a_beat;
            req_word_nxt  = a_word;
            issue_nxt     = '0;
            recv_nxt      = '0;
            mem_valid_nxt = 1'b1;
            mem_addr_nxt  = {a_tag, a_index, BW'(0), BEAT_SHIFT'(0)};
            cmd_ready_nxt = 1'b0;
            state_nxt     = ST_REFILL;
          end
        end
      end

      ST_REFILL: begin
        if (flush) begin
          flush_pend_nxt = 1'b1;
        end
        if (mem_cmd_valid && mem_cmd_ready) begin
          issue_nxt    = issue_cnt + BW'(1);
          mem_addr_nxt = {req_tag, req_index, BW'(issue_cnt + BW'(1)), BEAT_SHIFT'(0)};
          if (issue_cnt == BW'(LINE_BEATS - 1)) begin
            mem_valid_nxt = 1'b0;
          end
        end
        if (mem_rsp_valid) begin
          wr_en    = 1'b1;
          recv_nxt = recv_cnt + BW'(1);
          if (recv_cnt == req_beat) begin
            rd_en    = 1'b1;
            rd_index = req_index;
            rd_beat  = req_beat;
            rd_word  = req_word;
          end
          if (recv_cnt == BW'(LINE_BEATS - 1)) begin
            tag_en        = 1'b1;
            tag_valid     = !(flush_pend || flush);
            rsp_valid_nxt = 1'b1;
            state_nxt     = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        cmd_ready_nxt  = 1'b1;
        state_nxt      = ST_IDLE;
        clear_all      = flush_pend || flush;
        flush_pend_nxt = 1'b0;
      end

      default: begin
        state_nxt      = ST_IDLE;
        cmd_ready_nxt  = 1'b1;
        mem_valid_nxt  = 1'b0;
        flush_pend_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      issue_cnt     <= '0;
      recv_cnt      <= '0;
      req_index     <= '0;
      req_tag       <= '0;
      req_beat      <= '0;
      req_word      <= 1'b0;
      flush_pend    <= 1'b0;
      cpu_cmd_ready <= 1'b1;
      cpu_rsp_valid <= 1'b0;
      mem_cmd_valid <= 1'b0;
      mem_cmd_addr  <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state         <= state_nxt;
      issue_cnt     <= issue_nxt;
      recv_cnt      <= recv_nxt;
      req_index     <= req_index_nxt;
      req_tag       <= req_tag_nxt;
      req_beat      <= req_beat_nxt;
      req_word      <= req_word_nxt;
      flush_pend    <= flush_pend_nxt;
      cpu_cmd_ready <= cmd_ready_nxt;
      cpu_rsp_valid <= rsp_valid_nxt;
      mem_cmd_valid <= mem_valid_nxt;
      mem_cmd_addr  <= mem_addr_nxt;
      hit_count     <= hit_nxt;
      miss_count    <= miss_nxt;
    end
  end

endmodule
